// File: rtl/alu_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants and the decoded issue entry.
// Used by alu_op_decoder and alu_issue_stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_SUBU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ill;
    } decoded_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational MIPS ALU-instruction decoder: instruction word plus forwarded
// register values in, one decoded issue entry out.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int LUI_SH = 16
) (
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output decoded_t          entry
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rt_f;
    logic [REG_AW-1:0] rd_f;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_zx;
    logic              unused_rs_field;

    assign opcode = instr[31:26];
    assign rt_f   = instr[20:16];
    assign rd_f   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx = {{(DATA_W-16){1'b0}}, imm};

    // The rs index is resolved upstream; only its forwarded value arrives here.
    assign unused_rs_field = ^instr[25:21];

    logic              legal;
    logic [REG_AW-1:0] dest;
    decoded_t          raw;

    always_comb begin
        raw   = '0;
        legal = 1'b1;
        dest  = '0;
        if (opcode == OP_RTYPE) begin
            dest  = rd_f;
            raw.a = rs_val;
            raw.b = rt_val;
            case (funct)
                FN_ADD:  raw.op = ALU_ADD;
                FN_ADDU: raw.op = ALU_ADDU;
                FN_SUB:  raw.op = ALU_SUB;
                FN_SUBU: raw.op = ALU_SUBU;
                FN_AND:  raw.op = ALU_AND;
                FN_OR:   raw.op = ALU_OR;
                FN_XOR:  raw.op = ALU_XOR;
                FN_NOR:  raw.op = ALU_NOR;
                FN_SLT:  raw.op = ALU_SLT;
                FN_SLTU: raw.op = ALU_SLTU;
                FN_SLL: begin
                    raw.op = ALU_SLL;
                    raw.a  = {{(DATA_W-5){1'b0}}, shamt};
                end
                FN_SRL: begin
                    raw.op = ALU_SRL;
                    raw.a  = {{(DATA_W-5){1'b0}}, shamt};
                end
                FN_SRA: begin
                    raw.op = ALU_SRA;
                    raw.a  = {{(DATA_W-5){1'b0}}, shamt};
                end
                FN_SLLV: raw.op = ALU_SLL;
                FN_SRLV: raw.op = ALU_SRL;
                FN_SRAV: raw.op = ALU_SRA;
                default: legal = 1'b0;
            endcase
        end else begin
            dest  = rt_f;
            raw.a = rs_val;
            case (opcode)
                OP_ADDI: begin
                    raw.op = ALU_ADD;
                    raw.b  = imm_sx;
                end
                OP_ADDIU: begin
                    raw.op = ALU_ADDU;
                    raw.b  = imm_sx;
                end
                OP_SLTI: begin
                    raw.op = ALU_SLT;
                    raw.b  = imm_sx;
                end
                OP_SLTIU: begin
                    raw.op = ALU_SLTU;
                    raw.b  = imm_sx;
                end
                OP_ANDI: begin
                    raw.op = ALU_AND;
                    raw.b  = imm_zx;
                end
                OP_ORI: begin
                    raw.op = ALU_OR;
                    raw.b  = imm_zx;
                end
                OP_XORI: begin
                    raw.op = ALU_XOR;
                    raw.b  = imm_zx;
                end
                // LUI becomes imm << LUI_SH on the shifter.
                OP_LUI: begin
                    raw.op = ALU_SLL;
                    raw.a  = DATA_W'(LUI_SH);
                    raw.b  = imm_zx;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Illegal words retire as a non-writing bubble with zeroed operands.
    always_comb begin
        entry = '0;
        if (legal) begin
            entry    = raw;
            entry.rd = dest;
            entry.we = (dest != '0);
        end else begin
            entry.ill = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register feeding the ALU. Optional performance counters are
// enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int LUI_SH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_illegal,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [REG_AW-1:0] wr_reg,
    output logic              wr_en,
    output logic              illegal
);

    decoded_t dec;
    logic     accept;

    alu_op_decoder #(
        .LUI_SH (LUI_SH)
    ) u_decoder (
        .instr  (instr),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .entry  (dec)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Upstream may load whenever the register is empty or EX drains it this
    // cycle; while out_valid && !out_ready every output holds bit-stable.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            operation <= 4'b0000;
            data_a    <= '0;
            data_b    <= '0;
            wr_reg    <= '0;
            wr_en     <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wr_en     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            operation <= dec.op;
            data_a    <= dec.a;
            data_b    <= dec.b;
            wr_reg    <= dec.rd;
            wr_en     <= dec.we;
            illegal   <= dec.ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued  <= '0;
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            if (accept) begin
                perf_issued <= sat_inc(perf_issued);
            end
            if (out_valid && !out_ready) begin
                perf_stall <= sat_inc(perf_stall);
            end
            if (accept && dec.ill) begin
                perf_illegal <= sat_inc(perf_illegal);
            end
        end
    end
`endif

endmodule
